// File: rtl/btb_assoc.sv
// btb_assoc: set-associative branch target buffer with pseudo-LRU replacement and EX->IF forwarding.
// Optional build macro BTB_STATS_EN adds if_valid_i and the saturating lookup_cnt_o/hit_cnt_o counters.
module btb_assoc #(
  parameter int PC_W     = 64,
  parameter int NUM_SETS = 16,
  parameter int NUM_WAYS = 2,
  parameter int TAG_W    = 10,
  parameter int TGT_W    = 20,
  localparam int SEL_W   = $clog2(NUM_SETS),
  localparam int WAY_W   = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PC_W-1:0]  if_pc_i,
  input  logic             ex_is_br_i,
  input  logic             ex_is_cond_i,
  input  logic             ex_is_taken_i,
  input  logic [PC_W-1:0]  ex_pc_i,
  input  logic [PC_W-1:0]  ex_br_target_i,
`ifdef BTB_STATS_EN
  input  logic             if_valid_i,
  output logic [31:0]      lookup_cnt_o,
  output logic [31:0]      hit_cnt_o,
`endif
  output logic             hit_o,
  output logic             is_cond_o,
  output logic [PC_W-1:0]  target_pc_o,
  output logic [WAY_W-1:0] hit_way_o
);

  logic [NUM_WAYS-1:0] valid_r [NUM_SETS];
  logic [2:0]          plru_r  [NUM_SETS];
  logic [TAG_W-1:0]    tag_r   [NUM_SETS][NUM_WAYS];
  logic [TGT_W-1:0]    tgt_r   [NUM_SETS][NUM_WAYS];
  logic                cond_r  [NUM_SETS][NUM_WAYS];

  logic [SEL_W-1:0] if_sel_s, ex_sel_s;
  logic [TAG_W-1:0] if_tag_s, ex_tag_s;
  logic             if_hit_s, ex_hit_s, ex_inv_s, fwd_s;
  logic [WAY_W-1:0] if_way_s, ex_hit_way_s, ex_inv_way_s, ex_way_s;
  logic             unused_s;

  // Tree bits point at the LRU side: bit0 = root (ways 0-1 vs 2-3), bit1 = ways 0/1, bit2 = ways 2/3.
  function automatic logic [2:0] plru_touch(input logic [2:0] cur, input logic [1:0] way);
    logic [2:0] nxt;
    nxt = cur;
    if (NUM_WAYS == 32'sd4) begin
      nxt[0] = ~way[1];
      if (way[1] == 1'b0) nxt[1] = ~way[0];
      else                nxt[2] = ~way[0];
    end else if (NUM_WAYS == 32'sd2) begin
      nxt[0] = ~way[0];
    end else begin
      nxt = cur;
    end
    return nxt;
  endfunction

  function automatic logic [1:0] plru_victim(input logic [2:0] cur);
    logic [1:0] v;
    if (NUM_WAYS == 32'sd4) begin
      v[1] = cur[0];
      v[0] = cur[0] ? cur[2] : cur[1];
    end else if (NUM_WAYS == 32'sd2) begin
      v = {1'b0, cur[0]};
    end else begin
      v = 2'd0;
    end
    return v;
  endfunction

  assign if_sel_s = if_pc_i[SEL_W+1:2];
  assign if_tag_s = if_pc_i[TAG_W+SEL_W+1:SEL_W+2];
  assign ex_sel_s = ex_pc_i[SEL_W+1:2];
  assign ex_tag_s = ex_pc_i[TAG_W+SEL_W+1:SEL_W+2];
  assign fwd_s    = ex_is_br_i && (ex_pc_i[TAG_W+SEL_W+1:2] == if_pc_i[TAG_W+SEL_W+1:2]);
  assign unused_s = ^{ex_br_target_i[PC_W-1:TGT_W+2], ex_br_target_i[1:0],
                      ex_pc_i[PC_W-1:TAG_W+SEL_W+2], ex_pc_i[1:0]};

  // IF lookup: descending scan so the lowest matching way wins.
  always_comb begin
    if_hit_s = 1'b0;
    if_way_s = '0;
    for (int w = NUM_WAYS - 32'sd1; w >= 32'sd0; w--) begin
      if_way_s = (valid_r[if_sel_s][w] && (tag_r[if_sel_s][w] == if_tag_s)) ? WAY_W'(w) : if_way_s;
      if_hit_s = if_hit_s | (valid_r[if_sel_s][w] && (tag_r[if_sel_s][w] == if_tag_s));
    end
  end

  // EX lookup and write-way choice: hit way, else lowest invalid way, else PLRU victim.
  always_comb begin
    ex_hit_s     = 1'b0;
    ex_hit_way_s = '0;
    ex_inv_s     = 1'b0;
    ex_inv_way_s = '0;
    for (int w = NUM_WAYS - 32'sd1; w >= 32'sd0; w--) begin
      ex_hit_way_s = (valid_r[ex_sel_s][w] && (tag_r[ex_sel_s][w] == ex_tag_s)) ? WAY_W'(w) : ex_hit_way_s;
      ex_hit_s     = ex_hit_s | (valid_r[ex_sel_s][w] && (tag_r[ex_sel_s][w] == ex_tag_s));
      ex_inv_way_s = (!valid_r[ex_sel_s][w]) ? WAY_W'(w) : ex_inv_way_s;
      ex_inv_s     = ex_inv_s | !valid_r[ex_sel_s][w];
    end
    ex_way_s = ex_hit_s ? ex_hit_way_s :
               (ex_inv_s ? ex_inv_way_s : WAY_W'(plru_victim(plru_r[ex_sel_s])));
  end

  // Valid bits and PLRU state; an update coinciding with reset is discarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_r[s] <= '0;
        plru_r[s]  <= 3'd0;
      end
    end else if (ex_is_br_i && ex_is_taken_i) begin
      valid_r[ex_sel_s][ex_way_s] <= 1'b1;
      plru_r[ex_sel_s]            <= plru_touch(plru_r[ex_sel_s], 2'(ex_way_s));
    end else if (ex_is_br_i && ex_hit_s) begin
      valid_r[ex_sel_s][ex_hit_way_s] <= 1'b0;
    end
  end

  // Entry payload; contents are meaningless while the valid bit is clear.
  always_ff @(posedge clk) begin
    if (ex_is_br_i && ex_is_taken_i) begin
      tag_r[ex_sel_s][ex_way_s]  <= ex_tag_s;
      tgt_r[ex_sel_s][ex_way_s]  <= ex_br_target_i[TGT_W+1:2];
      cond_r[ex_sel_s][ex_way_s] <= ex_is_cond_i;
    end
  end

  // IF outputs: miss under reset, forwarded EX result on a same-PC update, else stored entry.
  always_comb begin
    hit_o       = 1'b0;
    is_cond_o   = 1'b0;
    hit_way_o   = '0;
    target_pc_o = if_pc_i + PC_W'(3'd4);
    if (rst) begin
      hit_o = 1'b0;
    end else if (fwd_s) begin
      if (ex_is_taken_i) begin
        hit_o       = 1'b1;
        is_cond_o   = ex_is_cond_i;
        hit_way_o   = ex_way_s;
        target_pc_o = {if_pc_i[PC_W-1:TGT_W+2], ex_br_target_i[TGT_W+1:2], 2'b00};
      end else begin
        hit_o = 1'b0;
      end
    end else if (if_hit_s) begin
      hit_o       = 1'b1;
      is_cond_o   = cond_r[if_sel_s][if_way_s];
      hit_way_o   = if_way_s;
      target_pc_o = {if_pc_i[PC_W-1:TGT_W+2], tgt_r[if_sel_s][if_way_s], 2'b00};
    end else begin
      hit_o = 1'b0;
    end
  end

`ifdef BTB_STATS_EN
  // Saturating lookup and hit counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lookup_cnt_o <= 32'd0;
      hit_cnt_o    <= 32'd0;
    end else begin
      if (if_valid_i && (lookup_cnt_o != 32'hFFFF_FFFF)) lookup_cnt_o <= lookup_cnt_o + 32'd1;
      else                                               lookup_cnt_o <= lookup_cnt_o;
      if (if_valid_i && hit_o && (hit_cnt_o != 32'hFFFF_FFFF)) hit_cnt_o <= hit_cnt_o + 32'd1;
      else                                                     hit_cnt_o <= hit_cnt_o;
    end
  end
`endif

endmodule

// File: tb/tb_btb_assoc.sv
// Directed self-checking bench for btb_assoc (default parameters); BTB_STATS_EN also checks the counters.
module tb_btb_assoc;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] if_pc_i = 64'h1000;
  logic        ex_is_br_i = 1'b0, ex_is_cond_i = 1'b0, ex_is_taken_i = 1'b0;
  logic [63:0] ex_pc_i = 64'h0, ex_br_target_i = 64'h0;
  logic        hit_o, is_cond_o;
  logic [63:0] target_pc_o;
  logic [0:0]  hit_way_o;
`ifdef BTB_STATS_EN
  logic        if_valid_i = 1'b0;
  logic [31:0] lookup_cnt_o, hit_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  logic [63:0] pool_pc   [32];
  logic [63:0] exp_tgt   [32];
  logic        exp_v     [32];
  logic        exp_cond  [32];
  logic [63:0] exp_way   [32];
  int          set_cnt   [16];

  always #5 clk = ~clk;

  btb_assoc dut (
    .clk            (clk),
    .rst            (rst),
    .if_pc_i        (if_pc_i),
    .ex_is_br_i     (ex_is_br_i),
    .ex_is_cond_i   (ex_is_cond_i),
    .ex_is_taken_i  (ex_is_taken_i),
    .ex_pc_i        (ex_pc_i),
    .ex_br_target_i (ex_br_target_i),
`ifdef BTB_STATS_EN
    .if_valid_i     (if_valid_i),
    .lookup_cnt_o   (lookup_cnt_o),
    .hit_cnt_o      (hit_cnt_o),
`endif
    .hit_o          (hit_o),
    .is_cond_o      (is_cond_o),
    .target_pc_o    (target_pc_o),
    .hit_way_o      (hit_way_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic look(input string tag, input logic [63:0] pc, input logic h, input logic c,
                      input logic [63:0] tgt, input logic [63:0] w);
    if_pc_i = pc;
    #1;
    check({tag, ".hit"},  64'(hit_o),     64'(h));
    check({tag, ".cond"}, 64'(is_cond_o), 64'(c));
    check({tag, ".tgt"},  target_pc_o,    tgt);
    check({tag, ".way"},  64'(hit_way_o), w);
  endtask

  task automatic upd(input logic [63:0] pc, input logic [63:0] tgt, input logic cond, input logic taken);
    @(negedge clk);
    if_pc_i        = 64'h0;
    ex_is_br_i     = 1'b1;
    ex_pc_i        = pc;
    ex_br_target_i = tgt;
    ex_is_cond_i   = cond;
    ex_is_taken_i  = taken;
    @(posedge clk);
    #1;
    ex_is_br_i = 1'b0;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    look("reset", 64'h1000, 1'b0, 1'b0, 64'h1004, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    look("empty", 64'h1000, 1'b0, 1'b0, 64'h1004, 64'd0);

    // Basic allocate and lookup
    upd(64'h1000, 64'h2040, 1'b1, 1'b1);
    look("basic", 64'h1000, 1'b1, 1'b1, 64'h2040, 64'd0);
    look("basic_other_set", 64'h1004, 1'b0, 1'b0, 64'h1008, 64'd0);

    // Eviction through PLRU in set 0
    upd(64'h2000, 64'h2100, 1'b0, 1'b1);
    upd(64'h3000, 64'h2200, 1'b1, 1'b1);
    look("evict_a", 64'h1000, 1'b0, 1'b0, 64'h1004, 64'd0);
    look("evict_b", 64'h2000, 1'b1, 1'b0, 64'h2100, 64'd1);
    look("evict_c", 64'h3000, 1'b1, 1'b1, 64'h2200, 64'd0);
    upd(64'h2000, 64'h4000, 1'b0, 1'b1);
    look("retgt_b", 64'h2000, 1'b1, 1'b0, 64'h4000, 64'd1);
    look("retgt_c", 64'h3000, 1'b1, 1'b1, 64'h2200, 64'd0);
    upd(64'h2000, 64'h0, 1'b0, 1'b0);
    look("nodup_b", 64'h2000, 1'b0, 1'b0, 64'h2004, 64'd0);
    upd(64'h7000, 64'h2300, 1'b1, 1'b1);
    upd(64'h8000, 64'h2400, 1'b0, 1'b1);
    look("plru_c", 64'h3000, 1'b0, 1'b0, 64'h3004, 64'd0);
    look("plru_d", 64'h7000, 1'b1, 1'b1, 64'h2300, 64'd1);
    look("plru_e", 64'h8000, 1'b1, 1'b0, 64'h2400, 64'd0);

    // Invalidate on not-taken hit
    do_reset();
    upd(64'h1000, 64'h2040, 1'b1, 1'b1);
    upd(64'h1000, 64'h0, 1'b1, 1'b0);
    look("inv_next", 64'h1004, 1'b0, 1'b0, 64'h1008, 64'd0);
    look("inv_a", 64'h1000, 1'b0, 1'b0, 64'h1004, 64'd0);

    // Same-cycle forwarding, allocating way 1 behind 0x1000 in way 0
    upd(64'h1000, 64'h2040, 1'b1, 1'b1);
    @(negedge clk);
    ex_is_br_i = 1'b1; ex_pc_i = 64'h5000; ex_is_taken_i = 1'b1;
    ex_br_target_i = 64'h6000; ex_is_cond_i = 1'b0;
    look("fwd_taken", 64'h5000, 1'b1, 1'b0, 64'h6000, 64'd1);
    @(posedge clk);
    #1;
    ex_is_br_i = 1'b0;
    look("fwd_commit", 64'h5000, 1'b1, 1'b0, 64'h6000, 64'd1);
    @(negedge clk);
    ex_is_br_i = 1'b1; ex_is_taken_i = 1'b0;
    look("fwd_nt", 64'h5000, 1'b0, 1'b0, 64'h5004, 64'd0);
    @(posedge clk);
    #1;
    ex_is_br_i = 1'b0;
    look("fwd_nt_commit", 64'h5000, 1'b0, 1'b0, 64'h5004, 64'd0);

    // Random fill over a pool of at most two tags per set, so nothing is evicted
    do_reset();
    for (int k = 0; k < 32; k++) begin
      logic [9:0] tg;
      tg = (k >= 16) ? (10'h2A5 ^ 10'(k % 16)) : (10'h15A ^ 10'(k % 16));
      pool_pc[k] = {48'h0, tg, 4'(k % 16), 2'b00};
      exp_v[k] = 1'b0; exp_cond[k] = 1'b0; exp_tgt[k] = 64'h0; exp_way[k] = 64'd0;
    end
    for (int s = 0; s < 16; s++) set_cnt[s] = 0;
    for (int n = 0; n < 100; n++) begin
      int          idx;
      logic [19:0] t20;
      logic        c;
      idx = $urandom_range(31, 0);
      t20 = 20'($urandom);
      c   = 1'($urandom_range(1, 0));
      upd(pool_pc[idx], {42'h0, t20, 2'b00}, c, 1'b1);
      if (!exp_v[idx]) begin
        exp_way[idx] = 64'(set_cnt[idx % 16]);
        set_cnt[idx % 16]++;
        exp_v[idx] = 1'b1;
      end
      exp_tgt[idx]  = {42'h0, t20, 2'b00};
      exp_cond[idx] = c;
      look("rand_upd", pool_pc[idx], 1'b1, c, exp_tgt[idx], exp_way[idx]);
    end
    for (int k = 0; k < 32; k++) begin
      if (exp_v[k]) look("rand_scan", pool_pc[k], 1'b1, exp_cond[k], exp_tgt[k], exp_way[k]);
      else          look("rand_scan", pool_pc[k], 1'b0, 1'b0, pool_pc[k] + 64'd4, 64'd0);
    end

    // Async reset mid-stream, with an update in flight
    upd(pool_pc[0], 64'h3330, 1'b1, 1'b1);
    look("pre_rst", pool_pc[0], 1'b1, 1'b1, 64'h3330, exp_v[0] ? exp_way[0] : 64'd0);
    @(negedge clk);
    ex_is_br_i = 1'b1; ex_pc_i = 64'h9000; ex_is_taken_i = 1'b1;
    ex_br_target_i = 64'h7770; ex_is_cond_i = 1'b1;
    #2;
    rst = 1'b1;
    look("in_rst", pool_pc[0], 1'b0, 1'b0, pool_pc[0] + 64'd4, 64'd0);
    @(posedge clk);
    #1;
    ex_is_br_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    look("rst_drop", 64'h9000, 1'b0, 1'b0, 64'h9004, 64'd0);
    look("rst_p0", pool_pc[0], 1'b0, 1'b0, pool_pc[0] + 64'd4, 64'd0);
    look("rst_p17", pool_pc[17], 1'b0, 1'b0, pool_pc[17] + 64'd4, 64'd0);

`ifdef BTB_STATS_EN
    // Five valid lookups, three of them hits
    do_reset();
    upd(64'h1000, 64'h2040, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if_valid_i = 1'b1;
      if_pc_i = (i % 2 == 0) ? 64'h1000 : 64'h2000;
    end
    @(negedge clk);
    if_valid_i = 1'b0;
    #1;
    check("lookup_cnt", 64'(lookup_cnt_o), 64'd5);
    check("hit_cnt", 64'(hit_cnt_o), 64'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
